hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 110 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight destination tracker producing stall and forwarding selects
// FORWARDING_EN: stall only on load-use and drive fwd_sel; otherwise stall on any in-flight match.
module hazard_scoreboard #(
  parameter int REG_AW = 4,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             id_valid,
  input  logic [REG_AW-1:0]                src1,
  input  logic [REG_AW-1:0]                src2,
  input  logic                             two_src,
  input  logic                             id_wb_en,
  input  logic                             id_mem_r,
  input  logic [REG_AW-1:0]                id_dest,
  input  logic                             flush,
  input  logic                             clr_cnt,
  output logic                             hazard,
  output logic [$clog2(STAGES+1)-1:0]      fwd_sel1,
  output logic [$clog2(STAGES+1)-1:0]      fwd_sel2,
  output logic [CNT_W-1:0]                 stall_cnt
);

  localparam int SW = $clog2(STAGES + 1);

  logic [STAGES:1]   r_valid;
  logic [STAGES:1]   r_wb_en;
  logic [STAGES:1]   r_mem_r;
  logic [REG_AW-1:0] r_dest [1:STAGES];
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [STAGES:1]   w_match1;
  logic [STAGES:1]   w_match2;
  logic              w_hazard;
  logic              w_issue;
  logic              w_unused_mem;

  always_comb begin
    w_match1 = '0;
    w_match2 = '0;
    for (int k = 1; k <= STAGES; k++) begin
      w_match1[k] = r_valid[k] & r_wb_en[k] & (r_dest[k] == src1);
      w_match2[k] = r_valid[k] & r_wb_en[k] & two_src & (r_dest[k] == src2);
    end
  end

`ifdef FORWARDING_EN
  logic [SW-1:0] w_sel1;
  logic [SW-1:0] w_sel2;

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    w_sel1 = '0;
    w_sel2 = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (w_match1[k]) w_sel1 = SW'(k);
      if (w_match2[k]) w_sel2 = SW'(k);
    end
    if (!id_valid) begin
      w_sel1 = '0;
      w_sel2 = '0;
    end
  end

  assign w_hazard = id_valid & ~flush & r_mem_r[1] & (w_match1[1] | w_match2[1]);
  assign fwd_sel1 = w_sel1;
  assign fwd_sel2 = w_sel2;
`else
  assign w_hazard = id_valid & ~flush & (|(w_match1 | w_match2));
  assign fwd_sel1 = '0;
  assign fwd_sel2 = '0;
`endif

  // Slot mem_r is only consulted at slot 1 (and not at all without forwarding).
  assign w_unused_mem = ^r_mem_r;

  assign w_issue   = id_valid & ~w_hazard & ~flush;
  assign hazard    = w_hazard;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_wb_en <= '0;
      r_mem_r <= '0;
      for (int k = 1; k <= STAGES; k++) r_dest[k] <= '0;
    end else begin
      for (int k = STAGES; k >= 2; k--) begin
        r_valid[k] <= r_valid[k-1];
        r_wb_en[k] <= r_wb_en[k-1];
        r_mem_r[k] <= r_mem_r[k-1];
        r_dest[k]  <= r_dest[k-1];
      end
      r_valid[1] <= w_issue;
      r_wb_en[1] <= w_issue & id_wb_en;
      r_mem_r[1] <= w_issue & id_mem_r;
      r_dest[1]  <= w_issue ? id_dest : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule
